// File: rtl/rio_uart_tx.sv
// rio_uart_tx: queues rio_out writes in a small FIFO and sends each byte as an 8N1 UART frame, LSB first.
module rio_uart_tx #(
  parameter int DEPTH = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rio_wr,
  input  logic [7:0]                 rio_data,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       busy,
  output logic                       tx
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic tx_n, push, pop, bit_end;
  assign full = level == LW'(DEPTH);
  assign busy = state != IDLE;
  assign push = rio_wr && !full;
  assign bit_end = bit_cnt == LAST;
  always_comb begin
    state_n = state;
    bit_cnt_n = (state == IDLE || bit_end) ? '0 : bit_cnt + CW'(1);
    idx_n = idx;
    shift_n = shift;
    tx_n = tx;
    pop = 1'b0;
    case (state)
      IDLE: if (level != '0) begin
        pop = 1'b1;
        state_n = START;
        tx_n = 1'b0;
        shift_n = mem[rd_ptr];
      end
      START: if (bit_end) begin
        state_n = DATA;
        tx_n = shift[0];
        idx_n = '0;
      end
      DATA: if (bit_end) begin
        if (idx == 3'd7) begin
          state_n = STOP;
          tx_n = 1'b1;
        end else begin
          shift_n = shift >> 1;
          idx_n = idx + 3'd1;
          tx_n = shift[1];
        end
      end
      STOP: if (bit_end) begin
        // Chain straight into the next start bit so queued bytes stream without an idle gap
        if (level != '0) begin
          pop = 1'b1;
          state_n = START;
          tx_n = 1'b0;
          shift_n = mem[rd_ptr];
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      idx <= '0;
      shift <= '0;
      tx <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      tx <= tx_n;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      level <= level + LW'(push) - LW'(pop);
      overflow <= overflow | (rio_wr & full);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rio_data;
  end
endmodule
